// File: rtl/data_ram_responder.sv
// MEM-stage data-memory responder: byte-lane SRAM with WAIT_CYCLES wait states and a one-cycle ready_o pulse.
// Optional macro DRAM_MISALIGN_CHECK_EN reports misaligned accesses on err_o and suppresses them.
module data_ram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  datatype_sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        stallreq_o,
  output logic [1:0]  dbg_state_o
);
  // Handshake: ce_i is a valid held by the initiator until it sees the one-cycle ready_o pulse;
  // the request is captured on the accepting edge and ce_i is ignored in DONE, so a held ce_i
  // re-issues only after the mandatory IDLE cycle. stallreq_o = ce_i & ~ready_o.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int AW = ADDR_WIDTH + 2;

  state_t          state;
  logic [3:0]      cnt;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [1:0]      sel_q;
  logic [31:0]     data_q;
  logic [31:0]     mem [2**ADDR_WIDTH];

  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [1:0]      req_sel;
  logic [31:0]     req_data;
  logic [ADDR_WIDTH-1:0] idx;
  logic            access;
  logic            misalign;
  logic [3:0]      be;
  logic [31:0]     wdata;
  logic [31:0]     rword;
  logic [31:0]     rdata;
  logic            unused_addr_bits;

  // With zero wait states the access happens on the accepting edge, so use the live inputs there.
  always_comb begin
    if (state == S_IDLE) begin
      req_we   = we_i;
      req_addr = addr_i[AW-1:0];
      req_sel  = datatype_sel_i;
      req_data = data_i;
    end else begin
      req_we   = we_q;
      req_addr = addr_q;
      req_sel  = sel_q;
      req_data = data_q;
    end
  end

  assign idx    = req_addr[AW-1:2];
  assign rword  = mem[idx];
  assign access = rst && ((state == S_IDLE && ce_i && WAIT_CYCLES == 0) ||
                          (state == S_WAIT && cnt == 4'd0));

  always_comb begin
    be    = 4'b1111;
    wdata = req_data;
    rdata = rword;
    case (req_sel)
      2'b00: begin
        be    = 4'b0001 << req_addr[1:0];
        wdata = {4{req_data[7:0]}};
        rdata = {24'd0, 8'(rword >> {req_addr[1:0], 3'b000})};
      end
      2'b01: begin
        be    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{req_data[15:0]}};
        rdata = {16'd0, (req_addr[1] ? rword[31:16] : rword[15:0])};
      end
      default: begin
        be    = 4'b1111;
        wdata = req_data;
        rdata = rword;
      end
    endcase
  end

`ifdef DRAM_MISALIGN_CHECK_EN
  assign misalign = (req_sel == 2'b11) ||
                    (req_sel == 2'b01 && req_addr[0]) ||
                    (req_sel == 2'b10 && req_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst) err_o <= 1'b0;
    else      err_o <= access && misalign;
  end
`else
  assign misalign = 1'b0;
  assign err_o    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      ready_o <= 1'b0;
      data_o  <= 32'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= 2'b00;
      data_q  <= 32'd0;
    end else begin
      ready_o <= access;
      if (access && (misalign || !req_we))
        data_o <= misalign ? 32'd0 : rdata;
      case (state)
        S_IDLE: begin
          if (ce_i) begin
            we_q   <= we_i;
            addr_q <= addr_i[AW-1:0];
            sel_q  <= datatype_sel_i;
            data_q <= data_i;
            if (WAIT_CYCLES == 0) begin
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_DONE;
          else             cnt   <= cnt - 4'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array is not reset; access already excludes cycles with rst low.
  always_ff @(posedge clk) begin
    if (access && req_we && !misalign) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign stallreq_o       = ce_i & ~ready_o;
  assign dbg_state_o      = state;
  assign unused_addr_bits = ^addr_i[31:AW];

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: two instances (WAIT_CYCLES=0 and 1) checked against a byte-addressed
// memory model with directed cases and randomized traffic.
module tb_data_ram_responder;
  localparam int AW    = 10;
  localparam int BYTES = 4 * (2 ** AW);

  logic        clk = 1'b0;
  logic        rst;
  logic        ce[2];
  logic        we[2];
  logic [31:0] addr[2];
  logic [31:0] wdata[2];
  logic [1:0]  sel[2];
  logic [31:0] rdata[2];
  logic        ready[2];
  logic        err[2];
  logic        stall[2];
  logic [1:0]  dbg[2];

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_ready[2];
  logic [31:0] exp_data[2];
  bit          exp_known[2];
  logic [31:0] exp_q[$];
  logic [7:0]  mb[int];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_ram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .ce_i(ce[0]), .we_i(we[0]), .addr_i(addr[0]),
    .datatype_sel_i(sel[0]), .data_i(wdata[0]), .data_o(rdata[0]), .ready_o(ready[0]),
    .err_o(err[0]), .stallreq_o(stall[0]), .dbg_state_o(dbg[0])
  );

  data_ram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .ce_i(ce[1]), .we_i(we[1]), .addr_i(addr[1]),
    .datatype_sel_i(sel[1]), .data_i(wdata[1]), .data_o(rdata[1]), .ready_o(ready[1]),
    .err_o(err[1]), .stallreq_o(stall[1]), .dbg_state_o(dbg[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 1) ? 1 : 0;
  endfunction

  function automatic bit misaligned(input logic [31:0] a, input logic [1:0] s);
`ifdef DRAM_MISALIGN_CHECK_EN
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  // Reference model: memory as a flat little-endian byte array, addresses modulo array size.
  task automatic model_issue(input int d, input logic w, input logic [31:0] a,
                             input logic [1:0] s, input logic [31:0] wd, output bit pushed);
    int nb, base;
    logic [31:0] e;
    bit kn;
    nb   = nbytes(s);
    base = int'(a[AW+1:0]) & ~(nb - 1);
    if (misaligned(a, s)) begin
      exp_data[d]  = 32'd0;
      exp_known[d] = 1'b1;
    end else if (w) begin
      for (int i = 0; i < nb; i++) mb[d*BYTES + base + i] = wd[8*i +: 8];
    end else begin
      e  = 32'd0;
      kn = 1'b1;
      for (int i = 0; i < nb; i++) begin
        if (mb.exists(d*BYTES + base + i)) e[8*i +: 8] = mb[d*BYTES + base + i];
        else kn = 1'b0;
      end
      exp_data[d]  = e;
      exp_known[d] = kn;
    end
    pushed = exp_known[d];
    if (pushed) exp_q.push_back(exp_data[d]);
  endtask

  // Driver: issues one request and returns sampled in the ready_o cycle with ce still high.
  task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [1:0] s,
                      input logic [31:0] wd, input bit scramble);
    int n, lat;
    bit b2b, pushed;
    @(negedge clk);
    b2b      = (ce[d] === 1'b1);
    ce[d]    = 1'b1;
    we[d]    = w;
    addr[d]  = a;
    sel[d]   = s;
    wdata[d] = wd;
    lat      = wait_of(d) + (b2b ? 2 : 1);
    model_issue(d, w, a, s, wd, pushed);
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (ready[d] === 1'b1 || n > 40) break;
      check("stall_busy", {31'd0, stall[d]}, 32'd1);
      if (scramble && n == 1 && !b2b) begin
        we[d]    = 1'($urandom_range(0, 1));
        addr[d]  = $urandom;
        sel[d]   = 2'($urandom_range(0, 3));
        wdata[d] = $urandom;
      end
    end
    check("latency", 32'(n), 32'(lat));
    check("stall_at_ready", {31'd0, stall[d]}, 32'd0);
    check("err", {31'd0, err[d]}, {31'd0, misaligned(a, s)});
    if (pushed) check("data", rdata[d], exp_q.pop_front());
    last_ready[d] = cyc;
  endtask

  task automatic idle(input int d, input int k);
    @(negedge clk);
    ce[d] = 1'b0;
    repeat (k) begin
      @(posedge clk);
      #1;
      check("idle_ready", {31'd0, ready[d]}, 32'd0);
      check("idle_stall", {31'd0, stall[d]}, 32'd0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ce[d] = 1'b1; we[d] = 1'b1; addr[d] = 32'h10; sel[d] = 2'b10; wdata[d] = 32'hCAFEF00D;
      exp_data[d] = 32'd0; exp_known[d] = 1'b1; last_ready[d] = 0;
    end

    // Reset held with a store pending: nothing completes, outputs stay at reset values.
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        check("rst_ready", {31'd0, ready[d]}, 32'd0);
        check("rst_data", rdata[d], 32'd0);
        check("rst_err", {31'd0, err[d]}, 32'd0);
        check("rst_stall", {31'd0, stall[d]}, 32'd1);
      end
    end
    @(negedge clk);
    rst = 1'b1; ce[0] = 1'b0; ce[1] = 1'b0;

    xact(1, 1'b0, 32'h10, 2'b10, 32'd0, 1'b0);
    check("rst_nowrite", {31'd0, rdata[1] !== 32'hCAFEF00D}, 32'd1);
    idle(1, 1);

    // Known contents for the randomized window 0x00..0x7F on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 32; w++) xact(d, 1'b1, 32'(w * 4), 2'b10, $urandom, 1'b0);
      idle(d, 1);
    end

    // Store/load round trip with input scrambling during WAIT.
    xact(1, 1'b1, 32'h20, 2'b10, 32'hDEADBEEF, 1'b1);
    idle(1, 0);
    xact(1, 1'b0, 32'h20, 2'b10, 32'd0, 1'b1);
    check("deadbeef", rdata[1], 32'hDEADBEEF);
    idle(1, 1);

    // Byte lanes.
    xact(1, 1'b1, 32'h40, 2'b10, 32'h11223344, 1'b0);
    xact(1, 1'b1, 32'h42, 2'b00, 32'h000000AA, 1'b0);
    xact(1, 1'b0, 32'h42, 2'b01, 32'd0, 1'b0);
    check("lanes_half", rdata[1], 32'h000011AA);
    xact(1, 1'b0, 32'h40, 2'b10, 32'd0, 1'b0);
    check("lanes_word", rdata[1], 32'h11AA3344);
    xact(1, 1'b0, 32'h43, 2'b00, 32'd0, 1'b0);
    check("lanes_byte", rdata[1], 32'h00000011);
    idle(1, 1);

    // Zero wait states, back-to-back loads.
    xact(0, 1'b1, 32'h44, 2'b10, 32'h0A0B0C0D, 1'b0);
    idle(0, 1);
    xact(0, 1'b0, 32'h20, 2'b10, 32'd0, 1'b0);
    p = last_ready[0];
    xact(0, 1'b0, 32'h44, 2'b10, 32'd0, 1'b0);
    check("b2b_gap", 32'(last_ready[0] - p), 32'd2);
    check("b2b_data", rdata[0], 32'h0A0B0C0D);
    idle(0, 1);

    // Address wrap.
    xact(1, 1'b1, 32'h1000, 2'b10, 32'h5, 1'b0);
    xact(1, 1'b0, 32'h0, 2'b10, 32'd0, 1'b0);
    check("wrap", rdata[1], 32'h00000005);
    idle(1, 1);

    // Misaligned word store.
    xact(1, 1'b1, 32'h40, 2'b10, 32'h12345678, 1'b0);
    xact(1, 1'b1, 32'h41, 2'b10, 32'hA5A5A5A5, 1'b0);
`ifdef DRAM_MISALIGN_CHECK_EN
    check("mis_err", {31'd0, err[1]}, 32'd1);
    check("mis_data", rdata[1], 32'd0);
    xact(1, 1'b0, 32'h40, 2'b10, 32'd0, 1'b0);
    check("mis_nowrite", rdata[1], 32'h12345678);
`else
    check("mis_err", {31'd0, err[1]}, 32'd0);
    xact(1, 1'b0, 32'h40, 2'b10, 32'd0, 1'b0);
    check("mis_write", rdata[1], 32'hA5A5A5A5);
`endif
    idle(1, 1);

    // Reset on the edge that would enter DONE: the store is discarded.
    @(negedge clk);
    ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h30; sel[1] = 2'b10; wdata[1] = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_ready", {31'd0, ready[1]}, 32'd0);
    check("rst_mid_data", rdata[1], 32'd0);
    exp_data[0] = 32'd0; exp_data[1] = 32'd0;
    exp_known[0] = 1'b1; exp_known[1] = 1'b1;
    @(negedge clk);
    rst = 1'b1; ce[1] = 1'b0;
    xact(1, 1'b0, 32'h30, 2'b10, 32'd0, 1'b0);
    check("rst_mid_nowrite", {31'd0, rdata[1] !== 32'h0BADF00D}, 32'd1);
    idle(1, 1);

    // Randomized traffic, including wrapped aliases and back-to-back requests.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        xact(d, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_F07F, 2'($urandom_range(0, 3)),
             $urandom, (d == 1) && ($urandom_range(0, 1) == 1));
        if ($urandom_range(0, 2) == 0) idle(d, $urandom_range(0, 2));
      end
      idle(d, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
